// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiplication uses one shift-add step per cycle and division uses one
// restoring shift-subtract step per cycle, both on operand magnitudes.
// The sign of each result is fixed up in the cycle that writes HI/LO.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    // r_acc holds {partial product} for MUL and {remainder, quotient} for DIV
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_opb;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic             r_divzero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_load;
    logic             w_step;
    logic             w_fin;
    logic             w_dz_fin;
    logic             w_last;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    logic [WIDTH:0]   w_mul_sum;
    logic [AW-1:0]    w_mul_nx;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_sub;
    logic             w_q_bit;
    logic [AW-1:0]    w_div_nx;

    logic [AW-1:0]    w_prod_neg;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign busy    = r_busy;
    assign done    = r_done;
    assign divZero = r_divzero;
    assign hi      = r_hi;
    assign lo      = r_lo;

    // Operand magnitudes; op[0] selects the signed variants
    always_comb begin
        w_a_neg = op[0] & in1[WIDTH-1];
        w_b_neg = op[0] & in2[WIDTH-1];
        w_a_mag = w_a_neg ? (~in1 + WIDTH'(1)) : in1;
        w_b_mag = w_b_neg ? (~in2 + WIDTH'(1)) : in2;
    end

    // One multiply step: conditionally add multiplicand to the upper half, shift right
    always_comb begin
        w_mul_sum = {1'b0, r_acc[AW-1:WIDTH]};
        if (r_acc[0]) begin
            w_mul_sum = {1'b0, r_acc[AW-1:WIDTH]} + {1'b0, r_opb};
        end
        w_mul_nx = {w_mul_sum, r_acc[WIDTH-1:1]};
    end

    // One restoring divide step: shift in next dividend bit, subtract if it fits
    always_comb begin
        w_rem_sh  = r_acc[AW-1:WIDTH-1];
        w_rem_sub = w_rem_sh - {1'b0, r_opb};
        w_q_bit   = ~w_rem_sub[WIDTH];
        w_div_nx  = {(w_q_bit ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                     r_acc[WIDTH-2:0], w_q_bit};
    end

    // Sign-corrected results written into HI/LO on completion
    always_comb begin
        w_prod_neg = ~r_acc + AW'(1);
        w_quo      = r_acc[WIDTH-1:0];
        w_rem      = r_acc[AW-1:WIDTH];
        if (r_is_div) begin
            w_res_lo = r_neg_q ? (~w_quo + WIDTH'(1)) : w_quo;
            w_res_hi = r_neg_r ? (~w_rem + WIDTH'(1)) : w_rem;
        end else begin
            w_res_lo = r_neg_q ? w_prod_neg[WIDTH-1:0]  : r_acc[WIDTH-1:0];
            w_res_hi = r_neg_q ? w_prod_neg[AW-1:WIDTH] : r_acc[AW-1:WIDTH];
        end
    end

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and step control
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_fin      = 1'b0;
        w_dz_fin   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_state_nx = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nx = S_FIN;
                end
            end
            S_DIV: begin
                if (r_dz) begin
                    w_dz_fin   = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_nx = S_FIN;
                    end
                end
            end
            S_FIN: begin
                w_fin      = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch and per-cycle iteration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_opb    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_load) begin
            r_acc    <= op[1] ? {WIDTH'(0), w_a_mag} : {WIDTH'(0), w_b_mag};
            r_opb    <= op[1] ? w_b_mag : w_a_mag;
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= op[1] & (in2 == WIDTH'(0));
        end else if (w_step) begin
            r_acc <= r_is_div ? w_div_nx : w_mul_nx;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_busy <= (w_state_nx != S_IDLE);
            r_done <= w_fin | w_dz_fin;
            if (w_fin) begin
                r_divzero <= 1'b0;
            end else if (w_dz_fin) begin
                r_divzero <= 1'b1;
            end
        end
    end

    // HI/LO: a completing operation takes priority over a direct write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fin) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else begin
            if (hiWe) begin
                r_hi <= wdata;
            end
            if (loWe) begin
                r_lo <= wdata;
            end
        end
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; all widths below use WIDTH=32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 Port: op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Port: in1  input  32  dividend or multiplicand (ALU operand A).
REQ-007 Port: in2  input  32  divisor or multiplier (ALU operand B).
REQ-008 Port: hiWe  input  1  direct write of wdata into HI (mthi).
REQ-009 Port: loWe  input  1  direct write of wdata into LO (mtlo).
REQ-010 Port: wdata  input  32  data for hiWe/loWe.
REQ-011 Port: busy  output  1  operation in progress; CPU stalls while high.
REQ-012 Port: done  output  1  one-cycle pulse; new HI/LO visible in this cycle.
REQ-013 Port: divZero  output  1  last DIV/DIVU had in2==0.
REQ-014 Port: hi  output  32  HI register (product high half / remainder).
REQ-015 Port: lo  output  32  LO register (product low half / quotient).

Function
REQ-016 The FSM SHALL have states IDLE, MUL, DIV, FIN; busy=1 exactly in MUL, DIV, FIN.
REQ-017 In IDLE with start=1 at edge E0: latch op, |in1|, |in2| (magnitudes for signed ops, raw for unsigned), result signs; clear iteration counter; go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-018 MUL SHALL perform one shift-add step per cycle; DIV one restoring shift-subtract step per cycle; after WIDTH steps (edges E1..E32) go to FIN.
REQ-019 At the edge leaving FIN (E33): apply sign correction, write hi/lo, set done=1, return to IDLE; total latency start-to-done = WIDTH+1 cycles.
REQ-020 MULT/MULTU: {hi,lo} = full 64-bit signed/unsigned product.
REQ-021 DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with sign of in1.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000 (no trap).
REQ-023 DIV/DIVU with in2==0: skip iterations; at E1 done=1, divZero=1, busy=0, hi/lo unchanged.
REQ-024 divZero SHALL be set/cleared at each completion and hold until the next completion.
REQ-025 start while busy=1 SHALL be ignored; operands may change freely while busy.
REQ-026 hiWe/loWe SHALL write wdata at the next edge in any state; a completion at the same edge overrides the direct write; a write during MUL/DIV is overwritten by the later completion.
REQ-027 done SHALL be 0 in every cycle except the single completion cycle; done and busy are never both 1.
REQ-028 start and hiWe/loWe in the same IDLE cycle: the direct write takes effect and the operation starts.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, busy=0, done=0, divZero=0, hi=0, lo=0, counter=0.
REQ-030 Reset during MUL/DIV/FIN SHALL abort the operation with no HI/LO update; the first start after release behaves normally.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 cycles after start, hi=0xFFFFFFFE, lo=0x00000001, busy high 33 cycles.
REQ-032 MULT 0xFFFFFFFA x 0x0000000B -> hi=0xFFFFFFFF, lo=0xFFFFFFBE; DIVU 6/11 -> lo=0, hi=6.
REQ-033 DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIV 5 / 0 with hi=0x11, lo=0x22 -> done one cycle after start, divZero=1, hi/lo unchanged; next MULTU 2x3 clears divZero, lo=6.
REQ-035 Second start mid-operation ignored (result matches first op); reset asserted 10 cycles into DIV -> all outputs 0 immediately, no done pulse.
REQ-036 hiWe with wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle; loWe during MUL -> overwritten by product at done.
